// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit placed after the register file read ports.
// It accepts one operation at a time. The operation runs a WIDTH-step shift-add multiply
// or a WIDTH-step restoring divide. When it finishes, the unit issues a one-cycle
// register write-back request.
//
// Optional feature: define MULDIV_SIGNED_EN to honour op_signed (two's complement operands).
// Without the macro, op_signed is ignored and every operation is unsigned.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   start      in   issue request, sampled only while idle
//   op         in   00 MUL, 01 MULH, 10 DIV, 11 REM
//   op_signed  in   signed request (MULDIV_SIGNED_EN builds only)
//   operand_a  in   multiplicand / dividend
//   operand_b  in   multiplier / divisor
//   dest_reg   in   destination register index
//   busy       out  operation in flight
//   done       out  one-cycle completion pulse
//   wb_write   out  register write enable (same as done)
//   wb_reg     out  destination register of the last result
//   wb_data    out  last result, held until the next completion
module muldiv_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    input  logic [REG_IDX_W-1:0] dest_reg,
    output logic                 busy,
    output logic                 done,
    output logic                 wb_write,
    output logic [REG_IDX_W-1:0] wb_reg,
    output logic [WIDTH-1:0]     wb_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0]     acc_lo;   // multiplier being shifted out / dividend->quotient
    logic [WIDTH-1:0]     opnd;     // multiplicand / divisor magnitude
    logic [1:0]           op_q;
    logic                 neg_res;  // product / quotient must be negated at finish
    logic                 neg_rem;  // remainder must be negated at finish
    logic [REG_IDX_W-1:0] dest_q;

    logic sign_en;
`ifdef MULDIV_SIGNED_EN
    assign sign_en = op_signed;
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign sign_en = 1'b0;
`endif

    logic             a_neg, b_neg, div0;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign a_neg = sign_en & operand_a[WIDTH-1];
    assign b_neg = sign_en & operand_b[WIDTH-1];
    assign mag_a = a_neg ? -operand_a : operand_a;
    assign mag_b = b_neg ? -operand_b : operand_b;
    assign div0  = op[1] && (operand_b == '0);

    // One iteration of either algorithm.
    logic [WIDTH:0]   mul_sum, rem_sh, diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd};
        step_hi = '0;
        step_lo = '0;
        if (op_q[1]) begin
            // The restoring step keeps the shifted remainder whenever the subtraction borrows.
            if (!diff[WIDTH]) begin
                step_hi = diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up and result select, applied on the edge that enters FIN.
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, result;

    always_comb begin
        product  = {acc_hi, acc_lo};
        prod_fix = neg_res ? -product : product;
        quot_fix = neg_res ? -acc_lo : acc_lo;
        rem_fix  = neg_rem ? -acc_hi : acc_hi;
        result   = '0;
        case (op_q)
            2'b00:   result = prod_fix[WIDTH-1:0];
            2'b01:   result = prod_fix[2*WIDTH-1:WIDTH];
            2'b10:   result = quot_fix;
            default: result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= StIdle;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dest_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_reg  <= '0;
            wb_data <= '0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        busy   <= 1'b1;
                        op_q   <= op;
                        dest_q <= dest_reg;
                        state  <= StRun;
                        if (div0) begin
                            // Preload the divide-by-zero results and skip the iterations,
                            // so the unit finishes on the next edge.
                            acc_hi  <= operand_a;
                            acc_lo  <= '1;
                            opnd    <= '0;
                            neg_res <= 1'b0;
                            neg_rem <= 1'b0;
                            cnt     <= CntLast;
                        end else begin
                            acc_hi  <= '0;
                            acc_lo  <= mag_a;
                            opnd    <= mag_b;
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            cnt     <= '0;
                        end
                    end
                end
                StRun: begin
                    if (cnt == CntLast) begin
                        state   <= StFin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        wb_data <= result;
                        wb_reg  <= dest_q;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CntOne;
                    end
                end
                StFin: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign wb_write = done;

endmodule
